// File: rtl/peripheral_bridge_apb2ahb.sv
// rtl/peripheral_bridge_apb2ahb.sv - APB4 slave to AHB-Lite master bridge, one AHB single transfer per APB transfer
module peripheral_bridge_apb2ahb #(
    parameter int PLEN = 8,
    parameter int XLEN = 32
) (
    input  logic                HRESETn,
    input  logic                HCLK,

    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic [PLEN-1:0]     PADDR,
    input  logic                PWRITE,
    input  logic [XLEN/8-1:0]   PSTRB,
    input  logic [XLEN-1:0]     PWDATA,
    output logic [XLEN-1:0]     PRDATA,
    output logic                PREADY,
    output logic                PSLVERR,

    output logic                HSEL,
    output logic [PLEN-1:0]     HADDR,
    output logic [XLEN-1:0]     HWDATA,
    input  logic [XLEN-1:0]     HRDATA,
    output logic                HWRITE,
    output logic [2:0]          HSIZE,
    output logic [2:0]          HBURST,
    output logic [3:0]          HPROT,
    output logic [1:0]          HTRANS,
    output logic                HMASTLOCK,
    input  logic                HREADY,
    input  logic                HRESP
);

    localparam int              LANES      = XLEN / 8;
    localparam logic [2:0]      SIZE_BUS   = (XLEN == 64) ? 3'b011 : 3'b010;
    localparam logic [PLEN-1:0] LANE_MASK  = PLEN'(LANES - 1);

    localparam logic [1:0]      ST_IDLE    = 2'd0;
    localparam logic [1:0]      ST_ADDR    = 2'd1;
    localparam logic [1:0]      ST_DATA    = 2'd2;
    localparam logic [1:0]      ST_RESP    = 2'd3;

    localparam logic [1:0]      HT_IDLE    = 2'b00;
    localparam logic [1:0]      HT_NONSEQ  = 2'b10;
    localparam logic [3:0]      HPROT_DATA = 4'b0011;

    logic [1:0]         r_state;
    logic               r_hsel;
    logic [PLEN-1:0]    r_haddr;
    logic [XLEN-1:0]    r_hwdata;
    logic               r_hwrite;
    logic [2:0]         r_hsize;
    logic [2:0]         r_hburst;
    logic [3:0]         r_hprot;
    logic [1:0]         r_htrans;
    logic               r_hmastlock;
    logic [XLEN-1:0]    r_prdata;
    logic               r_pready;
    logic               r_pslverr;

    logic               w_setup;
    logic               w_strb_zero;
    logic               w_strb_legal;
    logic [2:0]         w_strb_size;
    logic [PLEN-1:0]    w_strb_low;
    logic [PLEN-1:0]    w_addr_base;

    assign w_setup     = PSEL & ~PENABLE;
    assign w_strb_zero = (PSTRB == '0);
    assign w_addr_base = PADDR & ~LANE_MASK;

    // A legal strobe is 2^s contiguous lanes starting on a multiple of 2^s.
    always_comb begin
        w_strb_legal = 1'b0;
        w_strb_size  = 3'b000;
        w_strb_low   = '0;
        for (int s = 0; s < 4; s++) begin
            for (int o = 0; o < LANES; o++) begin
                if (((1 << s) <= LANES) && ((o % (1 << s)) == 0) &&
                    (32'(PSTRB) == 32'(((1 << (1 << s)) - 1) << o))) begin
                    w_strb_legal = 1'b1;
                    w_strb_size  = 3'(s);
                    w_strb_low   = PLEN'(o);
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= ST_IDLE;
            r_hsel      <= 1'b0;
            r_haddr     <= '0;
            r_hwdata    <= '0;
            r_hwrite    <= 1'b0;
            r_hsize     <= 3'b000;
            r_hburst    <= 3'b000;
            r_hprot     <= HPROT_DATA;
            r_htrans    <= HT_IDLE;
            r_hmastlock <= 1'b0;
            r_prdata    <= '0;
            r_pready    <= 1'b0;
            r_pslverr   <= 1'b0;
        end else begin
            r_hsel   <= 1'b0;
            r_htrans <= HT_IDLE;
            r_pready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_setup) begin
                        if (!PWRITE || w_strb_legal) begin
                            r_state  <= ST_ADDR;
                            r_hsel   <= 1'b1;
                            r_htrans <= HT_NONSEQ;
                            r_hwrite <= PWRITE;
                            if (PWRITE) begin
                                r_haddr  <= w_addr_base | w_strb_low;
                                r_hsize  <= w_strb_size;
                                r_hwdata <= PWDATA;
                            end else begin
                                r_haddr  <= w_addr_base;
                                r_hsize  <= SIZE_BUS;
                            end
                        end else begin
                            // Empty strobe completes silently; a malformed one reports an error.
                            r_state   <= ST_RESP;
                            r_pready  <= 1'b1;
                            r_pslverr <= ~w_strb_zero;
                        end
                    end
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        r_state <= ST_DATA;
                    end else begin
                        r_hsel   <= 1'b1;
                        r_htrans <= HT_NONSEQ;
                    end
                end
                ST_DATA: begin
                    if (HREADY) begin
                        r_state   <= ST_RESP;
                        r_pready  <= 1'b1;
                        r_pslverr <= HRESP;
                        if (!r_hwrite) begin
                            r_prdata <= HRDATA;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign HSEL      = r_hsel;
    assign HADDR     = r_haddr;
    assign HWDATA    = r_hwdata;
    assign HWRITE    = r_hwrite;
    assign HSIZE     = r_hsize;
    assign HBURST    = r_hburst;
    assign HPROT     = r_hprot;
    assign HTRANS    = r_htrans;
    assign HMASTLOCK = r_hmastlock;
    assign PRDATA    = r_prdata;
    assign PREADY    = r_pready;
    assign PSLVERR   = r_pslverr;

endmodule

// File: doc/peripheral_bridge_apb2ahb.md
PERIPHERAL_BRIDGE_APB2AHB -- requirements
Module: peripheral_bridge_apb2ahb

Interface
REQ-001 Parameters SHALL be:
- PLEN, default 8, address width.
- XLEN, default 32, data width; legal values are 32 and 64.
REQ-002 Clock and reset SHALL be: reset HRESETn, asynchronous, active-low; clock HCLK.
REQ-003 APB4 slave ports SHALL be:
- PSEL  in  1  APB select
- PENABLE  in  1  access phase
- PADDR  in  PLEN  address
- PWRITE  in  1  write
- PSTRB  in  XLEN/8  write strobes
- PWDATA  in  XLEN  write data
- PRDATA  out  XLEN  read data
- PREADY  out  1  transfer done
- PSLVERR  out  1  error
REQ-004 AHB-Lite master ports SHALL be:
- HSEL  out  1
- HADDR  out  PLEN
- HWDATA  out  XLEN
- HRDATA  in  XLEN
- HWRITE  out  1
- HSIZE  out  3
- HBURST  out  3
- HPROT  out  4
- HTRANS  out  2
- HMASTLOCK  out  1
- HREADY  in  1, connected to the slave's HREADYOUT
- HRESP  in  1

Function
REQ-005 The block SHALL convert each APB4 transfer into exactly one AHB-Lite single transfer, or none, with all outputs registered.
REQ-006 The FSM SHALL have states IDLE, ADDR, DATA and RESP:
- IDLE -> ADDR when PSEL=1 and PENABLE=0 and the strobe decode is legal.
- ADDR -> DATA when HREADY=1; ADDR holds while HREADY=0.
- DATA -> RESP when HREADY=1; DATA holds while HREADY=0.
- RESP -> IDLE unconditionally.
REQ-007 In ADDR the block SHALL drive:
- HSEL=1, HTRANS=NONSEQ (2'b10), HBURST=SINGLE (3'b000), HPROT=4'b0011, HMASTLOCK=0.
- HWRITE=PWRITE and HADDR=PADDR, with the low bits adjusted per REQ-009.
REQ-008 In every state other than ADDR the block SHALL drive HTRANS=IDLE and HSEL=0.
REQ-009 HSIZE SHALL be:
- Reads: XLEN size (WORD for 32, DWORD for 64), with HADDR aligned to XLEN/8 bytes.
- Writes: derived from PSTRB, and the PSTRB pattern must be one naturally aligned contiguous group of 1, 2, 4 or 8 lanes.
- HADDR low bits SHALL equal the index of the lowest set strobe lane.
REQ-010 Write strobe exceptions:
- A non-contiguous or misaligned PSTRB (e.g. 4'b0101, 4'b0110) SHALL skip the AHB transfer and go IDLE->RESP with PSLVERR=1.
- PSTRB=0 on a write SHALL skip the AHB transfer and go IDLE->RESP with PSLVERR=0.
REQ-011 HWDATA SHALL hold the captured PWDATA throughout DATA.
REQ-012 In DATA, with HREADY=1, the block SHALL:
- Capture HRDATA into PRDATA on reads.
- Capture HRESP into PSLVERR.
REQ-013 PREADY SHALL be 1 only in RESP, for exactly one cycle. PRDATA and PSLVERR SHALL be valid in that cycle and hold until the next RESP.
REQ-014 Minimum latency SHALL be as follows, with setup at cycle 0:
- Cycle 1: ADDR.
- Cycle 2: DATA.
- Cycle 3: RESP with PREADY=1.
- Each HREADY=0 cycle in ADDR or DATA SHALL add one cycle.
REQ-015 PSEL deasserting before RESP (protocol violation) SHALL NOT abort the AHB transfer; the block SHALL complete it and still pulse PREADY once.
REQ-016 A new APB setup presented in RESP SHALL be ignored; the next transfer SHALL be accepted only from IDLE.

Reset
REQ-017 On HRESETn=0, asynchronously, the block SHALL:
- Enter IDLE.
- Set HTRANS=IDLE, HSEL=0, HWRITE=0, HADDR=0, HWDATA=0, HSIZE=0, HBURST=0, HPROT=4'b0011, HMASTLOCK=0.
- Set PREADY=0, PSLVERR=0, PRDATA=0.
REQ-018 Reset asserted mid-transfer SHALL abandon the transfer with no PREADY pulse. After release, the first rising HCLK edge SHALL see IDLE.

Verification
REQ-019 Word write: PADDR=0x10, PSTRB=4'hF, PWDATA=0xDEADBEEF, HREADY=1 -> expected response:
- Cycle 1: HTRANS=NONSEQ, HADDR=0x10, HSIZE=WORD, HWRITE=1.
- Cycle 2: HWDATA=0xDEADBEEF.
- Cycle 3: PREADY=1, PSLVERR=0.
REQ-020 Halfword write: PADDR=0x20, PSTRB=4'b1100 -> HADDR=0x22, HSIZE=HWORD. Read back 0x20 -> HSIZE=WORD, PRDATA=HRDATA sampled in DATA.
REQ-021 Wait states: read with HREADY=0 for 2 cycles in DATA -> PREADY=1 at cycle 5, and HTRANS stays IDLE during the waits.
REQ-022 Illegal and empty strobes:
- PSTRB=4'b0101 -> no NONSEQ issued, PREADY=1 at cycle 1, PSLVERR=1.
- PSTRB=0 -> no NONSEQ issued, PSLVERR=0.
REQ-023 Error response: HRESP=1 in DATA -> PSLVERR=1 with PREADY. The next transfer with HRESP=0 -> PSLVERR=0.
REQ-024 Reset: HRESETn pulled low during DATA -> all outputs at REQ-017 values immediately, and no PREADY pulse afterwards.
